// File: rtl/antares_stall_controller.sv
// antares_stall_controller
// Central stall/flush sequencer for the five-stage pipeline. It merges
// per-stage stall requests into a back-to-front stall chain. It issues the
// stall and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB
// registers. It also owns the multi-cycle multiply/divide occupancy FSM.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   if_stall_req    instruction memory not ready
//   id_hazard_req   unresolvable data hazard in ID
//   ex_md_start     EX issues MULT/MULTU/DIV/DIVU
//   ex_md_div       qualifies ex_md_start (1 = divide)
//   ex_md_use       EX instruction needs the MD unit
//   mem_stall_req   data memory transaction outstanding
//   mem_exc_req     MEM instruction takes an exception
//   *_stall         hold the corresponding stage register
//   *_flush         clear the stage's critical control fields
//   md_busy         MD unit occupied
//   md_done         pulse on the last busy cycle
//   md_start_ok     MD start accepted; MD unit samples operands on this pulse
module antares_stall_controller #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic if_stall_req,
  input  logic id_hazard_req,
  input  logic ex_md_start,
  input  logic ex_md_div,
  input  logic ex_md_use,
  input  logic mem_stall_req,
  input  logic mem_exc_req,
  output logic if_stall,
  output logic id_stall,
  output logic ex_stall,
  output logic mem_stall,
  output logic wb_stall,
  output logic if_flush,
  output logic id_flush,
  output logic ex_flush,
  output logic mem_flush,
  output logic md_busy,
  output logic md_done,
  output logic md_start_ok
);

  localparam int CW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          exc_take;
  logic          start_acc;

  // An exception is only taken once MEM is no longer stalled.
  assign exc_take  = mem_exc_req & ~mem_stall_req;
  assign start_acc = ex_md_start & (state == IDLE) & ~mem_stall_req & ~exc_take;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; the counter runs regardless of pipeline stalls.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (start_acc) begin
          state_nxt = BUSY;
          cnt_nxt   = ex_md_div ? CW'(DIV_LAT - 1) : CW'(MULT_LAT - 1);
        end
      end
      BUSY: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: all combinational and held at 0 while rst is asserted.
  always_comb begin
    logic md_wait;
    logic ex_s;
    logic id_s;
    md_wait     = (state == BUSY) & ex_md_use;
    ex_s        = mem_stall_req | md_wait;
    id_s        = ex_s | id_hazard_req;

    if_stall    = 1'b0;
    id_stall    = 1'b0;
    ex_stall    = 1'b0;
    mem_stall   = 1'b0;
    wb_stall    = 1'b0;
    if_flush    = 1'b0;
    id_flush    = 1'b0;
    ex_flush    = 1'b0;
    mem_flush   = 1'b0;
    md_busy     = 1'b0;
    md_done     = 1'b0;
    md_start_ok = 1'b0;

    if (!rst) begin
      md_busy     = (state == BUSY);
      md_done     = (state == BUSY) & (cnt == '0);
      md_start_ok = start_acc;
      if (exc_take) begin
        // Squash the front of the pipe; stalls are overridden by the flush.
        if_flush  = 1'b1;
        id_flush  = 1'b1;
        ex_flush  = 1'b1;
        mem_flush = 1'b1;
      end else begin
        mem_stall = mem_stall_req;
        wb_stall  = mem_stall_req;
        ex_stall  = ex_s;
        id_stall  = id_s;
        if_stall  = id_s | if_stall_req;
      end
    end
  end

endmodule

// File: tb/tb_antares_stall_controller.sv
module tb_antares_stall_controller;

  logic clk = 1'b0;
  logic rst;
  logic if_stall_req, id_hazard_req, ex_md_start, ex_md_div, ex_md_use;
  logic mem_stall_req, mem_exc_req;
  logic if_stall, id_stall, ex_stall, mem_stall, wb_stall;
  logic if_flush, id_flush, ex_flush, mem_flush;
  logic md_busy, md_done, md_start_ok;

  always #5 clk = ~clk;

  antares_stall_controller #(.MULT_LAT(4), .DIV_LAT(32)) dut (
    .clk(clk), .rst(rst),
    .if_stall_req(if_stall_req), .id_hazard_req(id_hazard_req),
    .ex_md_start(ex_md_start), .ex_md_div(ex_md_div), .ex_md_use(ex_md_use),
    .mem_stall_req(mem_stall_req), .mem_exc_req(mem_exc_req),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
    .mem_stall(mem_stall), .wb_stall(wb_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush),
    .mem_flush(mem_flush),
    .md_busy(md_busy), .md_done(md_done), .md_start_ok(md_start_ok)
  );

  // Request bits: {if_stall_req, id_hazard_req, ex_md_start, ex_md_div,
  //                ex_md_use, mem_stall_req, mem_exc_req}
  localparam logic [6:0] R_NONE  = 7'b0000000;
  localparam logic [6:0] R_ALL   = 7'b1111111;
  localparam logic [6:0] R_IFREQ = 7'b1000000;
  localparam logic [6:0] R_HAZ   = 7'b0100000;
  localparam logic [6:0] R_START = 7'b0010000;
  localparam logic [6:0] R_DIV   = 7'b0001000;
  localparam logic [6:0] R_USE   = 7'b0000100;
  localparam logic [6:0] R_MSTL  = 7'b0000010;
  localparam logic [6:0] R_EXC   = 7'b0000001;

  // Expected bits: {if,id,ex,mem,wb stall, if,id,ex,mem flush, busy, done, start_ok}
  localparam logic [11:0] E_ZERO   = 12'b00000_0000_000;
  localparam logic [11:0] E_STALLA = 12'b11111_0000_000;
  localparam logic [11:0] E_STALLI = 12'b11000_0000_000;
  localparam logic [11:0] E_STALLF = 12'b10000_0000_000;
  localparam logic [11:0] E_EXSTL  = 12'b11100_0000_000;
  localparam logic [11:0] E_FLUSH  = 12'b00000_1111_000;
  localparam logic [11:0] E_BUSY   = 12'b00000_0000_100;
  localparam logic [11:0] E_DONE   = 12'b00000_0000_010;
  localparam logic [11:0] E_SOK    = 12'b00000_0000_001;

  typedef struct {
    string       name;
    logic [11:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic step(input string nm, input logic r, input logic [6:0] req,
                      input logic [11:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r;
    if_stall_req  = req[6];
    id_hazard_req = req[5];
    ex_md_start   = req[4];
    ex_md_div     = req[3];
    ex_md_use     = req[2];
    mem_stall_req = req[1];
    mem_exc_req   = req[0];
    e.name = nm;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  // Monitor: every cycle the DUT presents a fresh combinational output set.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [11:0] act;
      e   = sb.pop_front();
      act = {if_stall, id_stall, ex_stall, mem_stall, wb_stall,
             if_flush, id_flush, ex_flush, mem_flush,
             md_busy, md_done, md_start_ok};
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", e.name, act, e.exp);
      end
    end
  end

  initial begin
    int wait_cyc;
    rst = 1'b1;
    {if_stall_req, id_hazard_req, ex_md_start, ex_md_div, ex_md_use,
     mem_stall_req, mem_exc_req} = '0;

    // Reset with every request high
    step("reset0", 1'b1, R_ALL, E_ZERO);
    step("reset1", 1'b1, R_ALL, E_ZERO);
    step("idle0",  1'b0, R_NONE, E_ZERO);
    step("idle1",  1'b0, R_NONE, E_ZERO);

    // Stall chain
    step("chain_mem", 1'b0, R_MSTL, E_STALLA);
    step("chain_haz", 1'b0, R_HAZ, E_STALLI);
    step("chain_if",  1'b0, R_IFREQ, E_STALLF);
    step("use_idle",  1'b0, R_USE, E_ZERO);

    // Divide: busy T+1..T+32, done at T+32, dependent released at T+33
    step("div_start", 1'b0, R_START | R_DIV, E_SOK);
    for (int k = 1; k <= 32; k++) begin
      if (k == 5)
        step("div_restart", 1'b0, R_USE | R_START, E_EXSTL | E_BUSY);
      else if (k == 32)
        step("div_done", 1'b0, R_USE, E_EXSTL | E_BUSY | E_DONE);
      else
        step("div_busy", 1'b0, R_USE, E_EXSTL | E_BUSY);
    end
    step("div_release", 1'b0, R_USE, E_ZERO);

    // Multiply: start blocked by mem stall, accepted next cycle, done at +4
    step("mul_blocked", 1'b0, R_START | R_MSTL, E_STALLA);
    step("mul_start",   1'b0, R_START, E_SOK);
    step("mul_busy1",   1'b0, R_NONE, E_BUSY);
    step("mul_busy2",   1'b0, R_NONE, E_BUSY);
    step("mul_busy3",   1'b0, R_NONE, E_BUSY);
    step("mul_done",    1'b0, R_NONE, E_BUSY | E_DONE);
    step("mul_idle",    1'b0, R_NONE, E_ZERO);

    // Exception while an older multiply is in flight
    step("exc_mstart", 1'b0, R_START, E_SOK);
    step("exc_busy1",  1'b0, R_USE, E_EXSTL | E_BUSY);
    step("exc_flush",  1'b0, R_EXC | R_START | R_USE, E_FLUSH | E_BUSY);
    step("exc_busy3",  1'b0, R_NONE, E_BUSY);
    step("exc_done",   1'b0, R_NONE, E_BUSY | E_DONE);
    step("exc_idle",   1'b0, R_NONE, E_ZERO);

    // Exception suppresses a start from idle
    step("exc_nostart", 1'b0, R_EXC | R_START, E_FLUSH);
    step("exc_nobusy",  1'b0, R_NONE, E_ZERO);

    // Exception withheld during mem stall
    step("excm_hold0", 1'b0, R_EXC | R_MSTL, E_STALLA);
    step("excm_hold1", 1'b0, R_EXC | R_MSTL, E_STALLA);
    step("excm_hold2", 1'b0, R_EXC | R_MSTL, E_STALLA);
    step("excm_take",  1'b0, R_EXC, E_FLUSH);
    step("excm_after", 1'b0, R_NONE, E_ZERO);

    // Reset mid-divide aborts BUSY
    step("rst_dstart", 1'b0, R_START | R_DIV, E_SOK);
    step("rst_busy1",  1'b0, R_NONE, E_BUSY);
    step("rst_busy2",  1'b0, R_NONE, E_BUSY);
    step("rst_mid",    1'b1, R_NONE, E_ZERO);
    step("rst_post",   1'b0, R_NONE, E_ZERO);
    step("rst_post2",  1'b0, R_START, E_SOK);
    step("rst_post3",  1'b0, R_NONE, E_BUSY);

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/antares_stall_controller.md
# antares_stall_controller

Central stall/flush sequencer for the Antares five-stage pipeline. It merges per-stage stall requests into a consistent back-to-front stall chain and issues the stall and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It owns the multi-cycle multiply/divide occupancy FSM and holds younger instructions in EX while a HI/LO result is pending. It squashes the whole front of the pipe when MEM reports an exception.

## Interface
- MULT_LAT, 4: multiply latency in cycles (>= 1).
- DIV_LAT, 32: divide latency in cycles (>= 1, >= MULT_LAT).
- clk  in  1  main clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- if_stall_req  in  1  instruction memory not ready.
- id_hazard_req  in  1  data hazard detected in ID that forwarding cannot resolve.
- ex_md_start  in  1  EX instruction issues a MULT/MULTU/DIV/DIVU.
- ex_md_div  in  1  qualifies ex_md_start: 1 = divide, 0 = multiply.
- ex_md_use  in  1  EX instruction needs the MD unit (MFHI/MFLO/MTHI/MTLO or a new MD op).
- mem_stall_req  in  1  data memory transaction outstanding.
- mem_exc_req  in  1  instruction in MEM takes an exception this cycle.
- if_stall, id_stall, ex_stall, mem_stall, wb_stall  out  1 each  hold the corresponding stage register.
- if_flush, id_flush, ex_flush, mem_flush  out  1 each  clear the stage's critical control fields.
- md_busy  out  1  MD unit is occupied.
- md_done  out  1  one-cycle pulse on the last busy cycle.
- md_start_ok  out  1  MD start accepted this cycle; the MD unit samples its operands on this pulse.

## Operation
- Stall chain (combinational):
  - md_wait = md_busy & ex_md_use.
  - mem_stall = mem_stall_req.
  - ex_stall = mem_stall | md_wait.
  - id_stall = ex_stall | id_hazard_req.
  - if_stall = id_stall | if_stall_req.
  - wb_stall = mem_stall.
- A stage that stalls while the next stage does not inserts a bubble downstream. The downstream register does this itself from (own_stall & ~next_stall); no extra output is needed.
- Exception handling, when mem_exc_req = 1 and mem_stall_req = 0:
  - if_flush, id_flush, ex_flush and mem_flush are all 1.
  - All *_stall outputs are forced to 0.
  - An MD start in that cycle is suppressed, because that instruction is younger than the excepting one.
  - An in-flight MD operation continues, because it belongs to an older instruction.
- If mem_exc_req arrives during mem_stall_req, flushes are withheld and stalls follow the normal chain until mem_stall_req falls.
- MD FSM has two states, IDLE and BUSY, plus a down-counter cnt of width clog2(DIV_LAT).
  - md_start_ok = ex_md_start & ~md_busy & ~mem_stall & ~(mem_exc_req & ~mem_stall_req).
  - IDLE -> BUSY on md_start_ok. cnt loads DIV_LAT-1 when ex_md_div = 1, else MULT_LAT-1.
  - In BUSY, cnt decrements every cycle, whether or not stalls are active.
  - When cnt == 0 in BUSY, md_done = 1 and the FSM returns to IDLE the next cycle.
  - ex_md_start while BUSY is not accepted. That instruction stalls through ex_md_use and is re-presented.
- md_busy is 1 exactly in state BUSY.

## Timing
- Reset values:
  - All *_stall = 0 and all *_flush = 0.
  - md_busy = 0, md_done = 0, md_start_ok = 0.
  - FSM = IDLE, cnt = 0.
  - rst asserted mid-operation aborts BUSY on the next edge.
- Stall and flush outputs are same-cycle combinational; there is no registered latency.
- Start accepted at cycle T:
  - md_busy = 1 during T+1 .. T+LAT.
  - md_done = 1 at T+LAT.
  - A dependent ex_md_use instruction sees ex_stall = 1 through T+LAT and advances at the edge ending T+LAT+1.
- LAT = 1: busy and done for the single cycle T+1.
- A new start is accepted at the earliest in cycle T+LAT+1; there is no back-to-back overlap.

## Test plan
- Reset: rst=1 for 2 cycles with every request high -> all outputs 0. After release with no requests -> outputs remain 0.
- Stall chain: mem_stall_req=1 -> wb/mem/ex/id/if_stall all 1. id_hazard_req alone -> id_stall=1, if_stall=1, ex_stall=0, mem_stall=0.
- Divide: ex_md_start=1, ex_md_div=1 at T -> md_busy high T+1..T+32 and md_done at T+32. ex_md_use=1 from T+1 -> ex_stall=1 through T+32, 0 at T+33.
- Multiply under stall: start at T with mem_stall_req=1 at T -> not accepted. Start at T+1 with stall low -> md_done at T+5.
- Exception: md BUSY with mem_exc_req=1 and ex_md_start=1 -> all four flushes 1, stalls 0, no new start, md_done at the original cycle.
- Exception during mem stall: mem_exc_req=1 and mem_stall_req=1 for 3 cycles -> flushes 0, stalls 1. Flushes go high in the first cycle mem_stall_req=0.
